// File: rtl/ecc_pkg.sv
// Shared types and constants for the ECC sequencing controller: FSM states,
// operation and width codes, codeword lengths and masks.
package ecc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_ENCODE,
    S_NOISE,
    S_CHECK,
    S_CORRECT,
    S_DONE
  } state_t;

  localparam logic [1:0] CTRL_ENC  = 2'd0;
  localparam logic [1:0] CTRL_DEC  = 2'd1;
  localparam logic [1:0] CTRL_FULL = 2'd2;

  localparam logic [1:0] WID_SMALL  = 2'd0;
  localparam logic [1:0] WID_MEDIUM = 2'd1;
  localparam logic [1:0] WID_LARGE  = 2'd2;

  localparam int CW_LEN_SMALL  = 12;
  localparam int CW_LEN_MEDIUM = 21;
  localparam int CW_LEN_LARGE  = 38;

  localparam logic [37:0] MASK_SMALL  = 38'hFFF;
  localparam logic [37:0] MASK_MEDIUM = 38'h1FFFFF;
  localparam logic [37:0] MASK_LARGE  = 38'h3FFFFFFFFF;

  function automatic logic is_legal(input logic [1:0] ctrl, input logic [1:0] width);
    return (ctrl != 2'd3) && (width != 2'd3);
  endfunction

endpackage

// File: rtl/ecc_cw_mask.sv
// Width code to codeword mask and length; an illegal code yields an empty
// mask and zero length.
module ecc_cw_mask
  import ecc_pkg::*;
#(
  parameter int CW_WIDTH = 38
) (
  input  logic [1:0]          i_width,
  output logic [CW_WIDTH-1:0] o_mask,
  output logic [5:0]          o_len
);

  always_comb begin
    o_mask = '0;
    o_len  = '0;
    case (i_width)
      WID_SMALL: begin
        o_mask = CW_WIDTH'(MASK_SMALL);
        o_len  = 6'(CW_LEN_SMALL);
      end
      WID_MEDIUM: begin
        o_mask = CW_WIDTH'(MASK_MEDIUM);
        o_len  = 6'(CW_LEN_MEDIUM);
      end
      WID_LARGE: begin
        o_mask = CW_WIDTH'(MASK_LARGE);
        o_len  = 6'(CW_LEN_LARGE);
      end
      default: begin
        o_mask = '0;
        o_len  = '0;
      end
    endcase
  end

endmodule

// File: rtl/ecc_codec_ctrl.sv
// ECC sequencing controller: encode / decode / full-channel operations with
// single-bit correction. Optional error statistics under ECC_ERR_STATS_EN.
module ecc_codec_ctrl
  import ecc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int AMBA_WORD  = 32,
  parameter int CW_WIDTH   = 38,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            ctrl,
  input  logic [1:0]            codeword_width,
  input  logic [CW_WIDTH-1:0]   data_in,
  input  logic [CW_WIDTH-1:0]   noise,
  output logic [DATA_WIDTH-1:0] enc_data,
  input  logic [CW_WIDTH-1:0]   enc_cw,
  output logic [CW_WIDTH-1:0]   chk_cw,
  output logic                  chk_small,
  output logic                  chk_medium,
  input  logic [1:0]            chk_nof,
  input  logic [4:0]            chk_pos,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  output logic [1:0]            num_of_errors,
`ifdef ECC_ERR_STATS_EN
  input  logic                  stats_clr,
  output logic [STAT_WIDTH-1:0] single_cnt,
  output logic [STAT_WIDTH-1:0] double_cnt,
`endif
  output logic [CW_WIDTH-1:0]   cw_out
);

  if (DATA_WIDTH > AMBA_WORD || CW_WIDTH < DATA_WIDTH + 6 || STAT_WIDTH < 1) begin : g_cfg_check
    $error("ecc_codec_ctrl: inconsistent width parameters");
  end

  state_t                r_state, w_next;
  logic [1:0]            r_ctrl, r_width;
  logic [CW_WIDTH-1:0]   r_noise, r_work, r_cw_out;
  logic [DATA_WIDTH-1:0] r_enc_data;
  logic                  r_chk_small, r_chk_medium, r_cfg_err;
  logic [1:0]            r_nof, r_num;
  logic [4:0]            r_pos;

  logic [CW_WIDTH-1:0]   w_mask_in, w_mask_lat, w_data_m, w_corr;
  logic [5:0]            w_len_in, w_len_lat;
  logic                  w_legal, w_busy, w_done;
  logic [1:0]            w_num;
  logic [CW_WIDTH-1:0]   w_one;

  assign w_one   = {{(CW_WIDTH-1){1'b0}}, 1'b1};
  assign w_legal = is_legal(ctrl, codeword_width);
  assign w_data_m = data_in & w_mask_in;

  // Live width feeds LATCH; latched width feeds NOISE and CORRECT.
  ecc_cw_mask #(.CW_WIDTH(CW_WIDTH)) u_mask_in (
    .i_width (codeword_width),
    .o_mask  (w_mask_in),
    .o_len   (w_len_in)
  );

  ecc_cw_mask #(.CW_WIDTH(CW_WIDTH)) u_mask_lat (
    .i_width (r_width),
    .o_mask  (w_mask_lat),
    .o_len   (w_len_lat)
  );

  always_comb begin
    w_next = r_state;
    w_busy = 1'b1;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_busy = 1'b0;
        if (start) w_next = S_LATCH;
      end
      S_LATCH: begin
        if (!w_legal)               w_next = S_DONE;
        else if (ctrl == CTRL_DEC)  w_next = S_CHECK;
        else                        w_next = S_ENCODE;
      end
      S_ENCODE:  w_next = (r_ctrl == CTRL_FULL) ? S_NOISE : S_DONE;
      S_NOISE:   w_next = S_CHECK;
      S_CHECK:   w_next = S_CORRECT;
      S_CORRECT: w_next = S_DONE;
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_busy = 1'b0;
        w_next = S_IDLE;
      end
    endcase
  end

  // pos 0 names the overall parity bit, kept at the top of the codeword;
  // a position beyond the codeword means the error is not correctable.
  always_comb begin
    w_corr = r_work;
    w_num  = r_nof;
    if (r_nof == 2'd1) begin
      if (r_pos == 5'd0)
        w_corr = r_work ^ (w_one << (w_len_lat - 6'd1));
      else if ({1'b0, r_pos} <= w_len_lat)
        w_corr = r_work ^ (w_one << ({1'b0, r_pos} - 6'd1));
      else
        w_num = 2'd2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_ctrl       <= '0;
      r_width      <= '0;
      r_noise      <= '0;
      r_work       <= '0;
      r_cw_out     <= '0;
      r_enc_data   <= '0;
      r_chk_small  <= 1'b0;
      r_chk_medium <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_nof        <= '0;
      r_pos        <= '0;
      r_num        <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_LATCH: begin
          r_ctrl       <= ctrl;
          r_width      <= codeword_width;
          r_noise      <= noise;
          r_num        <= '0;
          r_cfg_err    <= !w_legal;
          r_chk_small  <= (codeword_width == WID_SMALL);
          r_chk_medium <= (codeword_width == WID_MEDIUM);
          if (w_legal) begin
            if (ctrl == CTRL_DEC) r_work     <= w_data_m;
            else                  r_enc_data <= w_data_m[DATA_WIDTH-1:0];
          end
        end
        S_ENCODE: begin
          r_work <= enc_cw & w_mask_lat;
          if (r_ctrl == CTRL_ENC) begin
            r_cw_out <= enc_cw & w_mask_lat;
            r_num    <= '0;
          end
        end
        S_NOISE: r_work <= r_work ^ (r_noise & w_mask_lat);
        S_CHECK: begin
          r_nof <= chk_nof;
          r_pos <= chk_pos;
        end
        S_CORRECT: begin
          r_work   <= w_corr;
          r_cw_out <= w_corr;
          r_num    <= w_num;
        end
        default: ;
      endcase
    end
  end

`ifdef ECC_ERR_STATS_EN
  logic [STAT_WIDTH-1:0] r_single_cnt, r_double_cnt;

  always_ff @(posedge clk) begin
    if (rst || stats_clr) begin
      r_single_cnt <= '0;
      r_double_cnt <= '0;
    end else if (w_done && !r_cfg_err) begin
      if (r_num == 2'd1 && r_single_cnt != '1) r_single_cnt <= r_single_cnt + 1'b1;
      if (r_num == 2'd2 && r_double_cnt != '1) r_double_cnt <= r_double_cnt + 1'b1;
    end
  end

  assign single_cnt = r_single_cnt;
  assign double_cnt = r_double_cnt;
`endif

  assign enc_data      = r_enc_data;
  assign chk_cw        = r_work;
  assign chk_small     = r_chk_small;
  assign chk_medium    = r_chk_medium;
  assign busy          = w_busy;
  assign done          = w_done;
  assign cfg_err       = r_cfg_err;
  assign num_of_errors = r_num;
  assign cw_out        = r_cw_out;

endmodule

// File: tb/tb_ecc_codec_ctrl.sv
// Directed bench for ecc_codec_ctrl with stub encoder and syndrome unit;
// statistics checks are compiled when ECC_ERR_STATS_EN is defined.
module tb_ecc_codec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  ctrl, codeword_width;
  logic [37:0] data_in, noise;
  logic [31:0] enc_data;
  logic [37:0] enc_cw;
  logic [37:0] chk_cw;
  logic        chk_small, chk_medium;
  logic [1:0]  chk_nof;
  logic [4:0]  chk_pos;
  logic        busy, done, cfg_err;
  logic [1:0]  num_of_errors;
  logic [37:0] cw_out;
`ifdef ECC_ERR_STATS_EN
  logic        stats_clr;
  logic [1:0]  single_cnt, double_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int lat;
  int pulses;

  always #5 clk = ~clk;

  // Stub encoder: flips a fixed pattern in the low 12 bits.
  assign enc_cw = {6'b0, enc_data} ^ 38'hA50;

  ecc_codec_ctrl #(.STAT_WIDTH(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .ctrl           (ctrl),
    .codeword_width (codeword_width),
    .data_in        (data_in),
    .noise          (noise),
    .enc_data       (enc_data),
    .enc_cw         (enc_cw),
    .chk_cw         (chk_cw),
    .chk_small      (chk_small),
    .chk_medium     (chk_medium),
    .chk_nof        (chk_nof),
    .chk_pos        (chk_pos),
    .busy           (busy),
    .done           (done),
    .cfg_err        (cfg_err),
    .num_of_errors  (num_of_errors),
`ifdef ECC_ERR_STATS_EN
    .stats_clr      (stats_clr),
    .single_cnt     (single_cnt),
    .double_cnt     (double_cnt),
`endif
    .cw_out         (cw_out)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called #1 after a posedge with the DUT idle; returns #1 after the edge
  // on which done is first seen, with lat = edges counted from the start edge.
  task automatic run_op(input logic [1:0] c, input logic [1:0] w, input logic [37:0] d,
                        input logic [37:0] n, input logic [1:0] nof, input logic [4:0] pos,
                        input bit hold, output int l);
    ctrl = c; codeword_width = w; data_in = d; noise = n;
    chk_nof = nof; chk_pos = pos; start = 1'b1;
    @(posedge clk); #1;
    start = hold;
    l = 1;
    while (!done && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; ctrl = '0; codeword_width = '0;
    data_in = '0; noise = '0; chk_nof = '0; chk_pos = '0;
`ifdef ECC_ERR_STATS_EN
    stats_clr = 1'b0;
`endif
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cw_out", cw_out, 0);
    chk("rst_num", num_of_errors, 0);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_enc_data", enc_data, 0);
    chk("rst_chk_cw", chk_cw, 0);
    chk("rst_chk_sm", {chk_small, chk_medium}, 0);
    rst = 1'b0;
    step();

    // Decode, Large, clean
    run_op(2'd1, 2'd2, 38'h2A5A5A5A5A, '0, 2'd0, 5'd0, 0, lat);
    chk("dec_l_lat", lat, 4);
    chk("dec_l_cw", cw_out, 38'h2A5A5A5A5A);
    chk("dec_l_num", num_of_errors, 0);
    chk("dec_l_cfg", cfg_err, 0);
    chk("dec_l_size", {chk_small, chk_medium}, 0);
    step();
    chk("dec_l_busy_after", busy, 0);

    // Decode, Medium, single error at pos 5; high bits of data_in masked off
    run_op(2'd1, 2'd1, 38'h3FFF0ABCDE, '0, 2'd1, 5'd5, 0, lat);
    chk("dec_m_lat", lat, 4);
    chk("dec_m_cw", cw_out, 38'h0ABCCE);
    chk("dec_m_num", num_of_errors, 1);
    chk("dec_m_size", {chk_small, chk_medium}, 2'b01);
    step();

    // Full channel, Small: noise flips bit 0, correction restores it
    run_op(2'd2, 2'd0, 38'h100000F05A, 38'h001, 2'd1, 5'd1, 0, lat);
    chk("full_s_lat", lat, 6);
    chk("full_s_cw", cw_out, 38'hA0A);
    chk("full_s_num", num_of_errors, 1);
    chk("full_s_enc_data", enc_data, 32'h05A);
    chk("full_s_size", {chk_small, chk_medium}, 2'b10);
    step();

    // Encode, Medium; stub error count must not leak into the result
    run_op(2'd0, 2'd1, 38'h1234, '0, 2'd2, 5'd3, 0, lat);
    chk("enc_m_lat", lat, 3);
    chk("enc_m_cw", cw_out, 38'h1864);
    chk("enc_m_num", num_of_errors, 0);
    step();

    // Decode, Small, position outside the codeword -> uncorrectable
    run_op(2'd1, 2'd0, 38'h5C3, '0, 2'd1, 5'd20, 0, lat);
    chk("dec_s_oob_lat", lat, 4);
    chk("dec_s_oob_cw", cw_out, 38'h5C3);
    chk("dec_s_oob_num", num_of_errors, 2);
    step();

    // Decode, Small, pos 0 -> overall parity bit 11 flipped
    run_op(2'd1, 2'd0, 38'h5C3, '0, 2'd1, 5'd0, 0, lat);
    chk("dec_s_p0_cw", cw_out, 38'hDC3);
    chk("dec_s_p0_num", num_of_errors, 1);
    step();

    // Illegal ctrl and illegal width
    run_op(2'd3, 2'd0, 38'h123, '0, 2'd1, 5'd1, 0, lat);
    chk("bad_ctrl_lat", lat, 2);
    chk("bad_ctrl_cfg", cfg_err, 1);
    chk("bad_ctrl_num", num_of_errors, 0);
    chk("bad_ctrl_cw", cw_out, 38'hDC3);
    step();
    run_op(2'd1, 2'd3, 38'h123, '0, 2'd1, 5'd1, 0, lat);
    chk("bad_wid_lat", lat, 2);
    chk("bad_wid_cfg", cfg_err, 1);
    step();

    // Start held through a whole operation: exactly one done, no requeue
    run_op(2'd1, 2'd2, 38'h11, '0, 2'd0, 5'd0, 1, lat);
    chk("held_lat", lat, 4);
    chk("held_cfg_cleared", cfg_err, 0);
    start = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) pulses++;
    end
    chk("held_extra_done", pulses, 0);
    chk("held_busy", busy, 0);

`ifdef ECC_ERR_STATS_EN
    stats_clr = 1'b1; step(); stats_clr = 1'b0;
    chk("stats_clr_single", single_cnt, 0);
    for (int i = 0; i < 4; i++) begin
      run_op(2'd1, 2'd1, 38'h0ABCDE, '0, 2'd1, 5'd5, 0, lat);
      step();
    end
    chk("stats_single_sat", single_cnt, 2'd3);
    chk("stats_double", double_cnt, 0);
    run_op(2'd1, 2'd0, 38'h5C3, '0, 2'd1, 5'd20, 0, lat);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    chk("stats_clr_vs_done_s", single_cnt, 0);
    chk("stats_clr_vs_done_d", double_cnt, 0);
`endif

    // Start held, reset asserted while in CHECK
    ctrl = 2'd1; codeword_width = 2'd2; data_in = 38'h3F; chk_nof = 2'd1; chk_pos = 5'd2;
    start = 1'b1;
    step();
    chk("abort_busy", busy, 1);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0; start = 1'b0;
    chk("abort_busy_clr", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_cw_out", cw_out, 0);
    chk("abort_chk_cw", chk_cw, 0);
    chk("abort_enc_data", enc_data, 0);
    chk("abort_num", num_of_errors, 0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done || busy) pulses++;
    end
    chk("abort_no_done", pulses, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_codec_ctrl.md
Name: ecc_codec_ctrl

Overview:
- Sequencing controller for the ECC datapath. Accepts one operation per start pulse: encode, decode, or full channel (encode, inject noise, decode).
- Drives the parity encoder and the syndrome/error-count unit in order and applies single-bit correction to the registered codeword.
- Reports the corrected codeword, error count and a one-cycle done pulse.
- Sits between the AMBA register file and the encoder/syndrome datapath.

Parameters:
- DATA_WIDTH, 32, max data bits (Large).
- AMBA_WORD, 32, register-file word width.
- CW_WIDTH, 38, max codeword width (DATA_WIDTH + 6 parity bits).
- STAT_WIDTH, 16, statistics counter width (optional feature only).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- start  in  1  operation request; sampled only in IDLE.
- ctrl  in  2  0 encode, 1 decode, 2 full channel, 3 illegal.
- codeword_width  in  2  0 Small (8b data, 12b cw), 1 Medium (16b, 21b), 2 Large (32b, 38b), 3 illegal.
- data_in  in  CW_WIDTH  data (encode/full) or received codeword (decode), LSB-aligned.
- noise  in  CW_WIDTH  XOR error pattern for full channel.
- enc_data  out  DATA_WIDTH  data to encoder.
- enc_cw  in  CW_WIDTH  encoder codeword (combinational from enc_data).
- chk_cw  out  CW_WIDTH  codeword to syndrome unit.
- chk_small, chk_medium  out  1  size decode to syndrome unit; both 0 = Large.
- chk_nof  in  2  syndrome unit error count (0, 1, 2).
- chk_pos  in  5  syndrome position; 0 = overall parity bit.
- busy  out  1  high from accepted start until DONE completes.
- done  out  1  one-cycle completion pulse.
- cfg_err  out  1  illegal ctrl/width, valid with done.
- num_of_errors  out  2  final error count, valid from done until the next accepted start.
- cw_out  out  CW_WIDTH  result codeword (encoded or corrected), held until the next accepted start.

Behaviour:
- Reset: state IDLE; all outputs 0, including enc_data, chk_cw, chk_small and chk_medium.
- States: IDLE, LATCH, ENCODE, NOISE, CHECK, CORRECT, DONE.
- IDLE:
  - start=1 moves to LATCH; busy rises next cycle.
  - Start pulses while busy are ignored (no queueing).
- LATCH:
  - Registers ctrl, codeword_width and noise.
  - Registers data_in masked to the current codeword length; bits above it are 0.
  - Illegal ctrl or width goes to DONE with cfg_err=1, num_of_errors=0 and cw_out unchanged.
  - Otherwise: encode/full go to ENCODE; decode goes to CHECK with chk_cw = masked data_in.
- ENCODE:
  - enc_data = latched data; enc_cw is captured into the working register.
  - Encode goes to DONE with cw_out = enc_cw and num_of_errors=0.
  - Full channel goes to NOISE.
- NOISE: working register ^= (noise masked to the codeword length), then go to CHECK.
- CHECK:
  - chk_cw, chk_small and chk_medium driven from registers; chk_nof and chk_pos registered.
  - Go to CORRECT.
- CORRECT:
  - nof=1 and pos in 1..(cw length-1): flip bit pos-1.
  - nof=1 and pos=0: flip MSB parity bit (bit cw length-1).
  - nof=1 and pos-1 >= cw length: no flip, num_of_errors forced to 2.
  - nof=0 or 2: no change.
  - Go to DONE.
- DONE: done=1 for one cycle; busy drops on the same edge that returns to IDLE. A start in this cycle is ignored.
- Latency from start sampled to done high: encode 3 cycles, decode 4, full channel 6.
- Width codes: only one of Small, Medium or Large is active at a time. Mask constants are 12'hFFF, 21'h1FFFFF and 38'h3FFFFFFFFF.
- Reset mid-operation: abort immediately, return to IDLE, no done pulse, outputs cleared.

Optional Feature:
- Macro ECC_ERR_STATS_EN.
- When defined, adds ports single_cnt and double_cnt (out, STAT_WIDTH each) and stats_clr (in, 1).
  - On each done without cfg_err, the counter for num_of_errors 1 or 2 increments, saturating at all-ones.
  - stats_clr zeroes both counters and has priority over an increment in the same cycle.
  - rst clears both counters.
- When undefined, these ports and the counters do not exist; all other behaviour is identical.

Decomposition:
- Package ecc_pkg holds:
  - state enum;
  - ctrl codes ENC/DEC/FULL;
  - width codes SMALL/MEDIUM/LARGE;
  - CW_LEN_{SMALL,MEDIUM,LARGE} = 12/21/38;
  - codeword mask constants.
- Sub-module ecc_cw_mask: combinational width code to CW_WIDTH mask and length, used by LATCH, NOISE and CORRECT.

Test Plan:
- Decode, Large, clean codeword, stub nof=0 -> done 4 cycles after start; num_of_errors=0; cw_out = data_in.
- Decode, Medium, stub nof=1, pos=5 -> cw_out = data_in ^ 21'h10; num_of_errors=1.
- Full channel, Small, noise=12'h001, stub nof=1, pos=1 -> cw_out = encoded value; done 6 cycles after start.
- Decode, Small, stub nof=1, pos=20 -> no flip; num_of_errors=2. Separately, ctrl=3 -> done with cfg_err=1 after 2 cycles.
- start held high through an operation; rst asserted in CHECK -> only one operation; after rst: IDLE, done never pulses, outputs 0.
- With ECC_ERR_STATS_EN and STAT_WIDTH=2: 4 single-error decodes -> single_cnt=3 (saturated). stats_clr together with done -> 0.
